// File: rtl/vc_output_arbiter_if.sv
// Bundle of the arbiter's source, destination and status signals.
// slave = arbiter side, master = transaction-layer/FIFO side.
interface vc_output_arbiter_if #(
    parameter int DATA_WIDTH = 6
);
    logic [3:0]            state;
    logic                  prio_mode;
    logic [3:0]            src_empty;
    logic [DATA_WIDTH-1:0] src_data0;
    logic [DATA_WIDTH-1:0] src_data1;
    logic [DATA_WIDTH-1:0] src_data2;
    logic [DATA_WIDTH-1:0] src_data3;
    logic [3:0]            dst_almost_full;
    logic [3:0]            src_pop;
    logic [3:0]            dst_push;
    logic [DATA_WIDTH-1:0] dst_data;
    logic [1:0]            grant_id;
    logic [7:0]            xfer_count;
    logic                  idle;

    modport slave (
        input  state, prio_mode, src_empty,
        input  src_data0, src_data1, src_data2, src_data3,
        input  dst_almost_full,
        output src_pop, dst_push, dst_data, grant_id, xfer_count, idle
    );

    modport master (
        output state, prio_mode, src_empty,
        output src_data0, src_data1, src_data2, src_data3,
        output dst_almost_full,
        input  src_pop, dst_push, dst_data, grant_id, xfer_count, idle
    );
endinterface

// File: rtl/vc_output_arbiter.sv
// Four-VC egress arbiter: combinational pop of the winner, registered push
// into the destination FIFO selected by the word's class field.
module vc_output_arbiter #(
    parameter int         DATA_WIDTH  = 6,
    parameter logic [3:0] ACTIVE_CODE = 4'b1000
) (
    input logic                clk,
    input logic                reset,
    vc_output_arbiter_if.slave bus
);
    logic [DATA_WIDTH-1:0] head [4];
    logic [1:0]            cls  [4];
    logic [3:0]            elig;
    logic                  active;

    logic                  gnt_vld;
    logic [1:0]            gnt_idx;
    logic [1:0]            rr_idx;

    logic [3:0]            dst_push_q, dst_push_d;
    logic [DATA_WIDTH-1:0] dst_data_q, dst_data_d;
    logic [1:0]            grant_id_q, grant_id_d;
    logic [7:0]            xfer_cnt_q, xfer_cnt_d;
    logic                  idle_q, idle_d;

    assign head[0] = bus.src_data0;
    assign head[1] = bus.src_data1;
    assign head[2] = bus.src_data2;
    assign head[3] = bus.src_data3;

    assign active = (bus.state == ACTIVE_CODE) && !reset;

    // A source blocked by its own destination never stalls the others.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cls[i]  = head[i][DATA_WIDTH-1 -: 2];
            elig[i] = active && !bus.src_empty[i] && !bus.dst_almost_full[cls[i]];
        end
    end

    // grant_id_q doubles as the round-robin pointer; search starts one past it.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        if (bus.prio_mode) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (!gnt_vld && elig[k]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = k[1:0];
                end
            end
        end else begin
            for (int unsigned k = 1; k <= 4; k++) begin
                rr_idx = grant_id_q + k[1:0];
                if (!gnt_vld && elig[rr_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_idx;
                end
            end
        end
    end

    always_comb begin
        dst_push_d = '0;
        dst_data_d = dst_data_q;
        grant_id_d = grant_id_q;
        xfer_cnt_d = xfer_cnt_q;
        idle_d     = (&bus.src_empty) && !gnt_vld;
        if (gnt_vld) begin
            dst_push_d = 4'b0001 << cls[gnt_idx];
            dst_data_d = head[gnt_idx];
            grant_id_d = gnt_idx;
            if (xfer_cnt_q != 8'hFF) begin
                xfer_cnt_d = xfer_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_push_q <= '0;
            dst_data_q <= '0;
            grant_id_q <= 2'd3;
            xfer_cnt_q <= '0;
            idle_q     <= 1'b1;
        end else begin
            dst_push_q <= dst_push_d;
            dst_data_q <= dst_data_d;
            grant_id_q <= grant_id_d;
            xfer_cnt_q <= xfer_cnt_d;
            idle_q     <= idle_d;
        end
    end

    assign bus.src_pop    = gnt_vld ? (4'b0001 << gnt_idx) : '0;
    assign bus.dst_push   = dst_push_q;
    assign bus.dst_data   = dst_data_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.xfer_count = xfer_cnt_q;
    assign bus.idle       = idle_q;
endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed self-checking bench for vc_output_arbiter.
module tb_vc_output_arbiter;
    localparam int DW = 6;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    vc_output_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    vc_output_arbiter #(
        .DATA_WIDTH (DW),
        .ACTIVE_CODE(4'b1000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] words [4];
        n_cmp = 0;
        n_err = 0;
        words[0] = 6'h01; words[1] = 6'h02; words[2] = 6'h03; words[3] = 6'h04;

        reset = 1'b1;
        bus.state = 4'b0000;
        bus.prio_mode = 1'b0;
        bus.src_empty = 4'hF;
        bus.src_data0 = words[0];
        bus.src_data1 = words[1];
        bus.src_data2 = words[2];
        bus.src_data3 = words[3];
        bus.dst_almost_full = 4'h0;
        tick();
        tick();
        chk("rst_push",  32'(bus.dst_push),   32'h0);
        chk("rst_data",  32'(bus.dst_data),   32'h0);
        chk("rst_gid",   32'(bus.grant_id),   32'h3);
        chk("rst_xfer",  32'(bus.xfer_count), 32'h0);
        chk("rst_idle",  32'(bus.idle),       32'h1);

        // Round-robin with all four sources requesting, all class 0
        reset = 1'b0;
        bus.state = 4'b1000;
        bus.src_empty = 4'h0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_pop", 32'(bus.src_pop), 32'(4'b0001 << (k % 4)));
            tick();
            chk("rr_push", 32'(bus.dst_push),   32'h1);
            chk("rr_gid",  32'(bus.grant_id),   32'(k % 4));
            chk("rr_data", 32'(bus.dst_data),   32'(words[k % 4]));
            chk("rr_xfer", 32'(bus.xfer_count), 32'(k + 1));
            chk("rr_idle", 32'(bus.idle),       32'h0);
        end

        // Fixed priority: VC1 wins until it empties, then VC2
        bus.prio_mode = 1'b1;
        bus.src_empty = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fp_pop1", 32'(bus.src_pop), 32'h2);
            tick();
            chk("fp_gid1", 32'(bus.grant_id), 32'h1);
            chk("fp_dat1", 32'(bus.dst_data), 32'h02);
        end
        bus.src_empty = 4'b1011;
        #1;
        chk("fp_pop2", 32'(bus.src_pop), 32'h4);
        tick();
        chk("fp_gid2",  32'(bus.grant_id),   32'h2);
        chk("fp_dat2",  32'(bus.dst_data),   32'h03);
        chk("fp_xfer",  32'(bus.xfer_count), 32'd9);

        // VC0 blocked by almost-full destination 2; VC3 (class 1) still flows
        bus.prio_mode = 1'b0;
        bus.src_empty = 4'b0110;
        bus.src_data0 = 6'h20;
        bus.src_data3 = 6'h15;
        bus.dst_almost_full = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("hol_pop", 32'(bus.src_pop), 32'h8);
            tick();
            chk("hol_push", 32'(bus.dst_push), 32'h2);
            chk("hol_data", 32'(bus.dst_data), 32'h15);
            chk("hol_gid",  32'(bus.grant_id), 32'h3);
        end
        bus.prio_mode = 1'b1;
        #1;
        chk("hol_fp_pop", 32'(bus.src_pop), 32'h8);
        tick();
        chk("hol_fp_push", 32'(bus.dst_push),   32'h2);
        chk("hol_xfer",    32'(bus.xfer_count), 32'd12);

        // Leaving ACTIVE right after a grant: in-flight word still pushed
        bus.prio_mode = 1'b0;
        bus.dst_almost_full = 4'h0;
        bus.src_empty = 4'b1110;
        bus.src_data0 = 6'h07;
        #1;
        chk("sd_pop0", 32'(bus.src_pop), 32'h1);
        tick();
        bus.state = 4'b0100;
        #1;
        chk("sd_pop1",  32'(bus.src_pop),    32'h0);
        chk("sd_push1", 32'(bus.dst_push),   32'h1);
        chk("sd_data1", 32'(bus.dst_data),   32'h07);
        chk("sd_xfer1", 32'(bus.xfer_count), 32'd13);
        chk("sd_idle1", 32'(bus.idle),       32'h0);
        tick();
        chk("sd_push2", 32'(bus.dst_push),   32'h0);
        chk("sd_data2", 32'(bus.dst_data),   32'h07);
        chk("sd_xfer2", 32'(bus.xfer_count), 32'd13);
        chk("sd_idle2", 32'(bus.idle),       32'h0);
        chk("sd_pop2",  32'(bus.src_pop),    32'h0);

        // Saturation of xfer_count: 13 + 242 = 255
        bus.state = 4'b1000;
        bus.src_empty = 4'h0;
        bus.src_data0 = 6'h01;
        bus.src_data3 = 6'h04;
        for (int k = 0; k < 241; k++) tick();
        chk("sat_fe", 32'(bus.xfer_count), 32'hFE);
        tick();
        chk("sat_ff", 32'(bus.xfer_count), 32'hFF);
        for (int k = 0; k < 58; k++) tick();
        chk("sat_hold", 32'(bus.xfer_count), 32'hFF);
        chk("sat_push", 32'(bus.dst_push),   32'h1);

        // Reset mid-stream
        reset = 1'b1;
        tick();
        chk("mrst_push", 32'(bus.dst_push),   32'h0);
        chk("mrst_xfer", 32'(bus.xfer_count), 32'h0);
        chk("mrst_gid",  32'(bus.grant_id),   32'h3);
        chk("mrst_idle", 32'(bus.idle),       32'h1);
        chk("mrst_data", 32'(bus.dst_data),   32'h0);

        // One class-2 transfer, then all sources empty: dst_data holds
        reset = 1'b0;
        bus.src_empty = 4'b1110;
        bus.src_data0 = 6'h2A;
        #1;
        chk("emp_pop0", 32'(bus.src_pop), 32'h1);
        tick();
        chk("emp_push0", 32'(bus.dst_push), 32'h4);
        chk("emp_data0", 32'(bus.dst_data), 32'h2A);
        bus.src_empty = 4'hF;
        #1;
        chk("emp_pop1", 32'(bus.src_pop), 32'h0);
        tick();
        chk("emp_push1", 32'(bus.dst_push),   32'h0);
        chk("emp_idle1", 32'(bus.idle),       32'h1);
        chk("emp_data1", 32'(bus.dst_data),   32'h2A);
        chk("emp_xfer1", 32'(bus.xfer_count), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vc_output_arbiter.md
Name: vc_output_arbiter

Overview:
- Shares the transaction layer's single egress path between four source virtual-channel FIFOs (VC0..VC3).
- Each granted word is routed to one of four destination FIFOs. The destination is chosen by the class field in the word.
- Arbitration is gated by the 4-bit one-hot state from the transaction layer state machine. Words move only while that state is ACTIVE (4'b1000).
- Destinations throttle the arbiter through their almost-full flags.

Parameters:
- DATA_WIDTH, 6, word width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination class (0..3). Must be >= 3.
- ACTIVE_CODE, 4'b1000, state encoding that enables arbitration.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- state  input  4  one-hot state from the transaction layer state machine.
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (VC0 highest).
- src_empty  input  4  per-source empty flag; bit i = VCi.
- src_data0..src_data3  input  DATA_WIDTH each  head word of VCi. The source FIFO is first-word-fall-through, so the head is valid when !src_empty[i].
- dst_almost_full  input  4  per-destination almost-full flag.
- src_pop  output  4  one-hot or zero; combinational pop of the granted source.
- dst_push  output  4  one-hot or zero, registered; push into the destination FIFO.
- dst_data  output  DATA_WIDTH  registered word accompanying dst_push.
- grant_id  output  2  registered index of the last granted source.
- xfer_count  output  8  registered count of words transferred; saturates.
- idle  output  1  registered; 1 when all sources are empty and no push is pending.

Behaviour:
- Reset values:
  - dst_push = 0, dst_data = 0, grant_id = 3 (so VC0 is searched first), xfer_count = 0, idle = 1.
  - The round-robin pointer is reset to 3.
- Reset has priority over every other input.
- Eligibility:
  - Source i is eligible when state == ACTIVE_CODE, src_empty[i] == 0, and dst_almost_full[class_i] == 0.
  - class_i = src_data_i[DATA_WIDTH-1:DATA_WIDTH-2].
  - An ineligible source never blocks other sources (no head-of-line blocking across VCs).
- Selection when prio_mode = 1: lowest-index eligible source.
- Selection when prio_mode = 0:
  - Search order is ptr+1, ptr+2, ptr+3, ptr, all modulo 4.
  - The first eligible source in that order wins.
  - ptr is the last granted index, updated only when a grant occurs.
- The pointer is updated in both modes, so switching modes mid-stream causes no glitch.
- Cycle timing:
  - Cycle N: src_pop[g] = 1 combinationally for the winner g. At most one bit is set. All bits are 0 when nothing is eligible.
  - Cycle N+1: dst_push[class_g] = 1, dst_data = the word sampled at N, grant_id = g, and xfer_count increments.
  - When there is no grant at N, dst_push = 0 at N+1 and dst_data holds its previous value.
- Throughput: one word per cycle sustained. Latency from pop to push is 1 cycle.
- Backpressure: almost_full must assert with at least 1 free entry, which absorbs the one in-flight word. The arbiter does not re-check full at push time.
- Leaving ACTIVE mid-operation:
  - No further pops occur from that cycle.
  - A word popped in the previous cycle is still pushed.
- init/RESET states from the controller behave like non-ACTIVE: no pops occur, and counters are untouched. Only reset clears the counters.
- xfer_count saturates at 8'hFF; it does not wrap.
- idle at N+1 = (&src_empty at N) and no grant at N.
- Simultaneous requests from all sources in round-robin mode: grants rotate VC0, VC1, VC2, VC3, VC0, ...

Test Plan:
- Reset, then state = 4'b1000, all src_empty = 0, prio_mode = 0, all classes 0, dst_almost_full = 0 -> src_pop sequence 0001, 0010, 0100, 1000, 0001; dst_push[0] = 1 each cycle from cycle 2; grant_id 0, 1, 2, 3, 0.
- prio_mode = 1, VC1 and VC2 non-empty -> src_pop = 0010 every cycle until VC1 empties, then 0100.
- VC0 head class 2 with dst_almost_full = 4'b0100, VC3 head class 1 -> VC0 is never popped; VC3 popped; dst_push = 0010 next cycle.
- state drops from 4'b1000 to 4'b0100 the cycle after a grant -> that word is still pushed; src_pop = 0 afterwards; idle stays 0 while sources are non-empty.
- 300 continuous transfers -> xfer_count reaches 8'hFF and holds; reset asserted mid-stream -> next cycle dst_push = 0, xfer_count = 0, grant_id = 3, idle = 1.
- All sources empty in ACTIVE -> src_pop = 0, dst_push = 0, idle = 1, dst_data unchanged.
